data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder on the MEM-stage side of the 16-bit pipelined processor.
- Accepts one read or one write per transaction from the MEM stage (MemRead/MemWrite, ALU address, store data).
- Freezes the pipeline with a stall output while it is busy, then presents read data and a one-cycle done pulse.
- Replaces the ideal single-cycle data memory so the hazard/stall path is exercised.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// MEM-stage data memory request/response bundle.
// The MEM stage drives requests as master; the responder answers as slave.
interface data_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] readData;
  logic                  done;
  logic                  stall;
  logic                  error;
  logic [15:0]           accessCount;

  modport master (
    output MemRead, MemWrite, address, writeData,
    input  readData, done, stall, error, accessCount
  );

  modport slave (
    input  MemRead, MemWrite, address, writeData,
    output readData, done, stall, error, accessCount
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: stalls the pipeline for LATENCY
// cycles per access, then pulses done with read data and a fault flag.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2
) (
  input logic                 clock,
  input logic                 reset_n,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] AddrLimit = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic [1:0] {OpRead, OpWrite, OpBoth} op_e;

  state_e                state_q;
  op_e                   op_q;
  logic [3:0]            count_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;
  logic [15:0]           access_count_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req;
  logic                  in_idle;
  logic                  commit;
  logic                  addr_ok;
  logic                  mem_we;
  op_e                   req_op;
  op_e                   eff_op;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] eff_data;
  logic [IdxW-1:0]       mem_idx;

  assign req     = bus.MemRead | bus.MemWrite;
  assign in_idle = (state_q == StIdle);

  always_comb begin
    req_op = OpRead;
    if (bus.MemRead && bus.MemWrite) begin
      req_op = OpBoth;
    end else if (bus.MemWrite) begin
      req_op = OpWrite;
    end
  end

  // With LATENCY=1 the accept edge is also the commit edge, so use live inputs.
  assign eff_op   = in_idle ? req_op        : op_q;
  assign eff_addr = in_idle ? bus.address   : addr_q;
  assign eff_data = in_idle ? bus.writeData : wdata_q;

  assign commit  = (in_idle && req && (LATENCY == 1)) ||
                   ((state_q == StBusy) && (count_q == 4'd1));
  assign addr_ok = ({1'b0, eff_addr} < AddrLimit);
  assign mem_idx = eff_addr[IdxW-1:0];
  assign mem_we  = commit && reset_n && addr_ok && (eff_op == OpWrite);

  // Array has no reset so its contents survive a pipeline reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_idx] <= eff_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      op_q           <= OpRead;
      count_q        <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      error_q        <= 1'b0;
      access_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            op_q    <= req_op;
            addr_q  <= bus.address;
            wdata_q <= bus.writeData;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StBusy;
              count_q <= 4'(LATENCY - 1);
            end
          end
        end
        StBusy: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
          error_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      if (commit) begin
        access_count_q <= access_count_q + 16'd1;
        error_q        <= !addr_ok || (eff_op == OpBoth);
        if (eff_op == OpRead) begin
          rdata_q <= addr_ok ? mem[mem_idx] : '0;
        end
      end
    end
  end

  // Stall must rise in the request cycle itself, hence the combinational idle path.
  assign bus.stall       = in_idle ? (req && reset_n) : (state_q == StBusy);
  assign bus.done        = (state_q == StResp);
  assign bus.error       = error_q;
  assign bus.readData    = rdata_q;
  assign bus.accessCount = access_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: vector table on a LATENCY=2 instance plus hand sequences for
// reset abort, counter wrap and back-to-back behaviour on a LATENCY=1 instance.
module tb_data_mem_responder;

  logic clock = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  data_mem_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus_a ();
  data_mem_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus_b ();

  data_mem_responder #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(2)
  ) u_dut_a (
    .clock  (clock),
    .reset_n(rst_a_n),
    .bus    (bus_a)
  );

  data_mem_responder #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(1)
  ) u_dut_b (
    .clock  (clock),
    .reset_n(rst_b_n),
    .bus    (bus_b)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One LATENCY=2 transaction on instance A; inputs are scrambled while busy.
  task automatic run_a(input vec_t v, input string tag);
    @(negedge clock);
    bus_a.MemRead   = v.rd;
    bus_a.MemWrite  = v.wr;
    bus_a.address   = v.addr;
    bus_a.writeData = v.wdata;
    #1;
    chk({tag, " stall c0"}, bus_a.stall, 1);
    chk({tag, " done c0"}, bus_a.done, 0);
    @(negedge clock);
    bus_a.address   = ~v.addr;
    bus_a.writeData = ~v.wdata;
    #1;
    chk({tag, " stall c1"}, bus_a.stall, 1);
    chk({tag, " done c1"}, bus_a.done, 0);
    @(negedge clock);
    bus_a.MemRead  = 1'b0;
    bus_a.MemWrite = 1'b0;
    #1;
    chk({tag, " stall resp"}, bus_a.stall, 0);
    chk({tag, " done resp"}, bus_a.done, 1);
    chk({tag, " error"}, bus_a.error, v.exp_err);
    chk({tag, " readData"}, bus_a.readData, v.exp_rdata);
    chk({tag, " accessCount"}, bus_a.accessCount, v.exp_cnt);
    @(negedge clock);
    #1;
    chk({tag, " done after"}, bus_a.done, 0);
    chk({tag, " error after"}, bus_a.error, 0);
    chk({tag, " readData held"}, bus_a.readData, v.exp_rdata);
  endtask

  initial begin
    logic       exp_stall_b [4];
    logic       exp_done_b  [4];
    logic [15:0] exp_cnt_b  [4];
    vec_t       v;

    vecs[0]  = '{1'b0, 1'b1, 16'd5,   16'hBEEF, 16'h0000, 1'b0, 16'd1};
    vecs[1]  = '{1'b1, 1'b0, 16'd5,   16'h0000, 16'hBEEF, 1'b0, 16'd2};
    vecs[2]  = '{1'b0, 1'b1, 16'd44,  16'h4444, 16'hBEEF, 1'b0, 16'd3};
    vecs[3]  = '{1'b0, 1'b1, 16'd300, 16'hDEAD, 16'hBEEF, 1'b1, 16'd4};
    vecs[4]  = '{1'b1, 1'b0, 16'd300, 16'h0000, 16'h0000, 1'b1, 16'd5};
    vecs[5]  = '{1'b1, 1'b0, 16'd44,  16'h0000, 16'h4444, 1'b0, 16'd6};
    vecs[6]  = '{1'b0, 1'b1, 16'd7,   16'h0777, 16'h4444, 1'b0, 16'd7};
    vecs[7]  = '{1'b1, 1'b1, 16'd7,   16'h1234, 16'h4444, 1'b1, 16'd8};
    vecs[8]  = '{1'b1, 1'b0, 16'd7,   16'h0000, 16'h0777, 1'b0, 16'd9};
    vecs[9]  = '{1'b0, 1'b1, 16'd9,   16'h0999, 16'h0777, 1'b0, 16'd10};
    vecs[10] = '{1'b1, 1'b0, 16'd9,   16'h0000, 16'h0999, 1'b0, 16'd11};
    vecs[11] = '{1'b0, 1'b1, 16'd255, 16'h00FF, 16'h0999, 1'b0, 16'd12};
    vecs[12] = '{1'b1, 1'b0, 16'd255, 16'h0000, 16'h00FF, 1'b0, 16'd13};
    vecs[13] = '{1'b1, 1'b0, 16'd256, 16'h0000, 16'h0000, 1'b1, 16'd14};

    exp_stall_b = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_done_b  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_cnt_b   = '{16'd1, 16'd2, 16'd2, 16'd3};

    // Reset with a request pending: stall must stay low.
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.MemRead = 1'b1;  bus_a.MemWrite = 1'b0;
    bus_a.address = '0;    bus_a.writeData = '0;
    bus_b.MemRead = 1'b0;  bus_b.MemWrite = 1'b0;
    bus_b.address = '0;    bus_b.writeData = '0;
    #12;
    chk("reset stall", bus_a.stall, 0);
    chk("reset done", bus_a.done, 0);
    chk("reset error", bus_a.error, 0);
    chk("reset readData", bus_a.readData, 0);
    chk("reset accessCount", bus_a.accessCount, 0);
    @(negedge clock);
    bus_a.MemRead = 1'b0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_a(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset pulse during the busy cycle of a write to addr 9.
    @(negedge clock);
    bus_a.MemWrite = 1'b1;  bus_a.address = 16'd9;  bus_a.writeData = 16'hAAAA;
    #1;
    chk("abort stall c0", bus_a.stall, 1);
    @(negedge clock);
    rst_a_n = 1'b0;
    #1;
    chk("abort stall in reset", bus_a.stall, 0);
    chk("abort done in reset", bus_a.done, 0);
    chk("abort accessCount", bus_a.accessCount, 0);
    @(negedge clock);
    bus_a.MemWrite = 1'b0;
    rst_a_n = 1'b1;
    #1;
    chk("abort stall after", bus_a.stall, 0);
    chk("abort done after", bus_a.done, 0);
    v = '{1'b1, 1'b0, 16'd9, 16'h0000, 16'h0999, 1'b0, 16'd1};
    run_a(v, "abort readback");

    // Counter wrap.
    @(negedge clock);
    u_dut_a.access_count_q = 16'hFFFF;
    v = '{1'b1, 1'b0, 16'd255, 16'h0000, 16'h00FF, 1'b0, 16'd0};
    run_a(v, "wrap");

    // LATENCY=1: write, then a read held across two accept/response pairs.
    @(negedge clock);
    bus_b.MemWrite = 1'b1;  bus_b.address = 16'd3;  bus_b.writeData = 16'h3333;
    #1;
    chk("l1 write stall", bus_b.stall, 1);
    chk("l1 write done c0", bus_b.done, 0);
    @(negedge clock);
    bus_b.MemWrite = 1'b0;
    bus_b.MemRead  = 1'b1;
    #1;
    chk("l1 write done", bus_b.done, 1);
    chk("l1 write stall resp", bus_b.stall, 0);
    chk("l1 write error", bus_b.error, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      chk($sformatf("l1 stall c%0d", c), bus_b.stall, exp_stall_b[c]);
      chk($sformatf("l1 done c%0d", c), bus_b.done, exp_done_b[c]);
      chk($sformatf("l1 accessCount c%0d", c), bus_b.accessCount, exp_cnt_b[c]);
      if (exp_done_b[c]) begin
        chk($sformatf("l1 readData c%0d", c), bus_b.readData, 16'h3333);
      end
    end
    bus_b.MemRead = 1'b0;
    @(negedge clock);
    #1;
    chk("l1 idle done", bus_b.done, 0);
    chk("l1 final count", bus_b.accessCount, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
